// File: rtl/jesd204_tx_fec_header.sv
// JESD204C TX stage: one-cycle block pass-through that carries the 26-bit FEC in the sync-header stream.
// Optional define JESD204_FEC_HDR_ERR_INJECT_EN adds inject_err to corrupt fec[0] of one header word.

module jesd204_fec_encode #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [25:0]           fec
);
  // g(x) = (x^17+1)(x^9+x^4+1) = x^26+x^21+x^17+x^9+x^4+1, x^26 term implicit
  localparam logic [25:0] POLY = 26'h0220211;

  function automatic logic [25:0] step(input logic [25:0] s_in, input logic [DATA_WIDTH-1:0] d);
    logic [25:0] s;
    logic        fb;
    s = s_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb = d[i] ^ s[25];
      s  = {s[24:0], 1'b0} ^ (fb ? POLY : 26'd0);
    end
    return s;
  endfunction

  logic [25:0] base;
  assign base = rst ? 26'd0 : fec;

  // rst together with shift_en restarts the code word with data_in
  always_ff @(posedge clk) begin
    if (shift_en) fec <= step(base, data_in);
    else          fec <= base;
  end
endmodule

module jesd204_tx_fec_header #(
  parameter int DATA_WIDTH    = 64,
  parameter int BLOCKS_PER_MB = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_mb_start,
  input  logic                  in_eoemb,
`ifdef JESD204_FEC_HDR_ERR_INJECT_EN
  input  logic                  inject_err,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_header,
  output logic                  out_valid,
  output logic                  out_mb_start,
  output logic                  status_realign
);
  typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;

  state_t         state;
  logic [4:0]     blk_cnt;
  logic           act;
  logic [31:0]    hdr;
  logic [1:0]     enc_rst, enc_shift;
  logic [1:0][25:0] enc_fec;

  logic start_idle, misplaced, wrap, restart, blk0, next_act, hdr_bit, inj_apply;
  logic [25:0] fec_field;
  logic [31:0] hdr_new;

  assign start_idle = (state == IDLE) & in_valid & in_mb_start;
  assign misplaced  = (state != IDLE) & in_valid & in_mb_start & (blk_cnt != 5'd0);
  assign wrap       = (state != IDLE) & in_valid & (blk_cnt == 5'd0);
  assign restart    = start_idle | misplaced;
  assign blk0       = restart | wrap;
  assign next_act   = restart ? 1'b0 : (wrap ? ~act : act);

`ifdef JESD204_FEC_HDR_ERR_INJECT_EN
  logic inj_flag;
  assign inj_apply = inj_flag | (in_valid & inject_err);
  always_ff @(posedge clk) begin
    if (rst)                          inj_flag <= 1'b0;
    else if (blk0)                    inj_flag <= 1'b0;
    else if (in_valid & inject_err)   inj_flag <= 1'b1;
  end
`else
  assign inj_apply = 1'b0;
`endif

  // A freshly aligned multiblock has no predecessor, so its FEC field is zero
  assign fec_field = (restart ? 26'd0 : enc_fec[act]) ^ {25'd0, inj_apply};
  assign hdr_new   = {5'b00001, in_eoemb & in_mb_start, fec_field};
  // Block k carries hdr[31-k]; block 0 always carries 0
  assign hdr_bit   = ((state == IDLE) | blk0) ? 1'b0 : hdr[~blk_cnt];

  for (genvar i = 0; i < 2; i++) begin : g_enc
    assign enc_rst[i]   = rst | (state == IDLE) | misplaced | (wrap & (act == i[0]));
    assign enc_shift[i] = ~rst & in_valid & ((state != IDLE) | in_mb_start) & (next_act == i[0]);

    jesd204_fec_encode #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
      .clk      (clk),
      .rst      (enc_rst[i]),
      .shift_en (enc_shift[i]),
      .data_in  (in_data),
      .fec      (enc_fec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data       <= '0;
      out_header     <= 2'b01;
      out_valid      <= 1'b0;
      out_mb_start   <= 1'b0;
      status_realign <= 1'b0;
      state          <= IDLE;
      blk_cnt        <= 5'd0;
      act            <= 1'b0;
      hdr            <= '0;
    end else begin
      out_valid      <= in_valid;
      out_mb_start   <= in_valid & blk0;
      status_realign <= misplaced;
      if (in_valid) begin
        out_data   <= in_data;
        out_header <= hdr_bit ? 2'b10 : 2'b01;
      end
      if (blk0) hdr <= hdr_new;
      if (blk0)                             blk_cnt <= 5'd1;
      else if (in_valid && state != IDLE)   blk_cnt <= blk_cnt + 5'd1;
      act <= next_act;
      if (restart)                        state <= FIRST;
      else if (wrap && state == FIRST)    state <= RUN;
    end
  end
endmodule

// File: tb/tb_jesd204_tx_fec_header.sv
// Randomized bench for jesd204_tx_fec_header against a long-division Fire-code reference model.
module tb_jesd204_tx_fec_header;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid, in_mb_start, in_eoemb;
  logic        inject_err;
  logic [63:0] out_data;
  logic [1:0]  out_header;
  logic        out_valid, out_mb_start, status_realign;

  always #5 clk = ~clk;

  jesd204_tx_fec_header dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_mb_start    (in_mb_start),
    .in_eoemb       (in_eoemb),
`ifdef JESD204_FEC_HDR_ERR_INJECT_EN
    .inject_err     (inject_err),
`endif
    .out_data       (out_data),
    .out_header     (out_header),
    .out_valid      (out_valid),
    .out_mb_start   (out_mb_start),
    .status_realign (status_realign)
  );

  int n_checks = 0;
  int n_err    = 0;
  int gap_pct  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: remainder of m(x)*x^26 by g(x), first transmitted bit is the highest degree
  function automatic bit [25:0] golden(input bit [63:0] mb[32]);
    bit        a[2074];
    bit [26:0] g;
    bit [25:0] r;
    g = 27'h4220211;
    for (int i = 0; i < 2074; i++) a[i] = 1'b0;
    for (int i = 0; i < 2048; i++) a[i] = mb[i / 64][i % 64];
    for (int i = 0; i < 2048; i++)
      if (a[i]) for (int j = 0; j <= 26; j++) a[i + j] ^= g[26 - j];
    for (int j = 0; j < 26; j++) r[25 - j] = a[2048 + j];
    return r;
  endfunction

  bit [63:0] cur_mb[32];
  bit [63:0] prev_mb[32];
  int        mk;
  bit        aligned, have_prev, m_inj;
  bit [31:0] m_hdr;
  bit [63:0] exp_data;
  bit [1:0]  exp_hdr;
  bit        exp_valid, exp_mbs, exp_realign;

  task automatic model_reset();
    aligned = 0; have_prev = 0; mk = 0; m_inj = 0; m_hdr = '0;
    exp_data = '0; exp_hdr = 2'b01; exp_valid = 0; exp_mbs = 0; exp_realign = 0;
  endtask

  task automatic model(input bit v, input bit [63:0] d, input bit s, input bit e, input bit inj);
    bit        b0;
    bit [25:0] f;
    exp_valid = v; exp_mbs = 0; exp_realign = 0;
    if (!v) return;
    exp_data = d;
    if (inj) m_inj = 1;
    b0 = 0;
    if (!aligned) begin
      if (s) begin aligned = 1; have_prev = 0; b0 = 1; end
    end else if (s && mk != 0) begin
      exp_realign = 1; have_prev = 0; b0 = 1;
    end else if (mk == 0) b0 = 1;
    if (b0) begin
      f = have_prev ? golden(prev_mb) : 26'd0;
      f[0] ^= m_inj;
      m_inj = 0;
      m_hdr = {5'b00001, e & s, f};
      mk = 0;
    end
    exp_hdr = (aligned && m_hdr[31 - mk]) ? 2'b10 : 2'b01;
    exp_mbs = b0;
    if (aligned) begin
      cur_mb[mk] = d;
      mk++;
      if (mk == 32) begin prev_mb = cur_mb; have_prev = 1; mk = 0; end
    end
  endtask

  task automatic cycle(input bit v, input bit [63:0] d, input bit s, input bit e, input bit inj, input bit r);
    rst = r; in_valid = v; in_data = d; in_mb_start = s; in_eoemb = e; inject_err = inj;
    if (r) model_reset();
    else   model(v, d, s, e, inj);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_data", out_data, exp_data);
    chk("out_header", 64'(out_header), 64'(exp_hdr));
    chk("out_mb_start", 64'(out_mb_start), 64'(exp_mbs));
    chk("status_realign", 64'(status_realign), 64'(exp_realign));
  endtask

  task automatic send_block(input bit [63:0] d, input bit s, input bit e, input bit inj);
    while ($urandom_range(99) < gap_pct)
      cycle(0, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 0, 0);
    cycle(1, d, s, e, inj, 0);
  endtask

  // kind: 0 all-zero, 1 single leading one, 2 random
  task automatic send_mb(input int kind, input bit s0, input bit e);
    bit [63:0] d;
    for (int b = 0; b < 32; b++) begin
      d = (kind == 0) ? 64'd0 : (kind == 1) ? ((b == 0) ? 64'd1 : 64'd0) : {$urandom, $urandom};
      send_block(d, (b == 0) ? s0 : 1'b0, (b == 0) ? e : 1'b0, 0);
    end
  endtask

  initial begin
    model_reset();
    rst = 1; in_valid = 0; in_data = '0; in_mb_start = 0; in_eoemb = 0; inject_err = 0;
    cycle(1, 64'hdead_beef_0123_4567, 1, 1, 0, 1);
    cycle(0, 64'd0, 0, 0, 0, 1);

    // unaligned traffic: headers stay 01
    for (int i = 0; i < 3; i++) cycle(1, {$urandom, $urandom}, 0, 0, 0, 0);
    for (int m = 0; m < 4; m++) send_mb(0, 1, 0);

    send_mb(1, 1, 0);
    send_mb(0, 1, 0);
    send_mb(0, 1, 0);

    gap_pct = 30;
    for (int m = 0; m < 8; m++)
      send_mb(2, ($urandom_range(3) != 0), (m % 4 == 3));
    gap_pct = 0;

    // misplaced start at block 17
    for (int b = 0; b < 17; b++) send_block({$urandom, $urandom}, (b == 0), 0, 0);
    for (int b = 0; b < 32; b++) send_block({$urandom, $urandom}, (b == 0), 0, 0);
    for (int m = 0; m < 3; m++) send_mb(2, 1, 0);

    // reset mid-multiblock, then realign
    for (int b = 0; b < 10; b++) send_block({$urandom, $urandom}, (b == 0), 0, 0);
    cycle(1, {$urandom, $urandom}, 0, 0, 0, 1);
    cycle(0, 64'd0, 0, 0, 0, 0);
    cycle(1, {$urandom, $urandom}, 0, 0, 0, 0);
    for (int m = 0; m < 3; m++) send_mb(2, 1, 0);

`ifdef JESD204_FEC_HDR_ERR_INJECT_EN
    for (int b = 0; b < 32; b++)
      send_block({$urandom, $urandom}, (b == 0), 0, (b == 10) || (b == 20));
    for (int m = 0; m < 3; m++) send_mb(2, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/jesd204_tx_fec_header.md
Name: jesd204_tx_fec_header

Overview:
- JESD204C 64B/66B transmit stage that carries FEC in the sync-header stream of each 32-block (2048-bit) multiblock.
- Passes 64-bit blocks through with one cycle of latency and drives two internal jesd204_fec_encode instances (DATA_WIDTH=64) in ping-pong.
- Builds the 32-bit sync-header word for multiblock m from the 26-bit FEC of multiblock m-1, then emits it one 2-bit header per block.
- Sits between the TX scrambler and the 66-bit gearbox.

Parameters:
- DATA_WIDTH, 64, block width; only 64 is supported.
- BLOCKS_PER_MB, 32, blocks per multiblock; the header word is 32 bits.

Ports:
- clk  input  1  link clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  64  scrambled block; in_data[0] is the first transmitted bit.
- in_valid  input  1  block present this cycle; gaps are allowed.
- in_mb_start  input  1  qualified by in_valid; marks block 0 of a multiblock.
- in_eoemb  input  1  sampled with in_mb_start; this multiblock ends an extended multiblock.
- out_data  output  64  registered copy of in_data.
- out_header  output  2  sync header: 2'b01 encodes header bit 0, 2'b10 encodes header bit 1.
- out_valid  output  1  out_data/out_header valid.
- out_mb_start  output  1  out_data is block 0.
- status_realign  output  1  one-cycle pulse on misplaced in_mb_start.

Behaviour:
- Reset values: out_data=0, out_header=2'b01, out_valid=0, out_mb_start=0, status_realign=0; state=IDLE; blk_cnt=0; both encoders held in reset.
- Latency: out_* updates the cycle after an in_valid cycle. out_valid=in_valid delayed by 1. With in_valid=0, out_data/out_header hold and out_valid=0.
- Header word for multiblock m: hdr[31:0]={5'b00001, eoemb_m, fec_{m-1}[25:0]}. Block k carries hdr[31-k], so blocks 0-3 carry 0, block 4 carries 1, block 5 carries eoemb, blocks 6-31 carry fec[25]..fec[0].
- States:
  - IDLE: no valid in_mb_start seen yet; headers 2'b01, encoders idle.
  - FIRST: first multiblock after alignment; fec field forced to 0.
  - RUN: fec field taken from the previous multiblock.
- Transitions:
  - IDLE->FIRST on in_valid&in_mb_start.
  - FIRST->RUN when blk_cnt wraps 31->0.
  - RUN stays in RUN.
- blk_cnt (5-bit) advances only on in_valid and wraps 31->0 autonomously. In FIRST/RUN, in_mb_start is optional when blk_cnt==0.
- Misplaced in_mb_start (in_valid&in_mb_start with blk_cnt!=0, in FIRST or RUN):
  - status_realign pulses.
  - That block is treated as block 0.
  - State goes to FIRST and both encoders are cleared; the active one is cleared and restarted with this word.
- Encoder contract: rst clears state synchronously; after the last shift_en word, fec is stable until the next rst or shift_en.
- Ping-pong scheme:
  - Encoder A accumulates even multiblocks and B odd ones. shift_en=in_valid for the active instance; data_in=in_data.
  - When block 0 of multiblock m is registered to the output, the finished instance's fec is latched into hdr.
  - The finished instance is pulsed in rst on that same cycle, then idles until its next multiblock.
- eoemb_m is latched from in_eoemb at block 0 of m; it is 0 if that block 0 had no in_mb_start.
- Simultaneous rst and in_valid: rst wins and the block is dropped.
- rst mid-multiblock: return to IDLE; output goes low next cycle.

Optional Feature:
- JESD204_FEC_HDR_ERR_INJECT_EN: adds input inject_err (1 bit).
  - Enabled: inject_err=1 on any in_valid cycle arms a flag. The next latched hdr has fec[0] inverted, then the flag clears. Multiple pulses before a latch arm it only once.
  - Disabled: no port and no logic; headers are always the true FEC.

Test Plan:
- All-zero data, in_mb_start every 32nd valid block, in_eoemb=0 -> after the first multiblock, per-multiblock out_header sequence is 01,01,01,01,10,01, then 26x 01; out_data equals in_data delayed 1 cycle.
- Multiblock 0 = {1'b1,2047'b0} (same MSb-first ordering the encoder bench uses), multiblock 1 all-zero -> header bits 6-31 of multiblock 1 equal the golden Fire-code fec of that pattern; multiblock 2 fec field is 0.
- in_eoemb=1 on every 4th multiblock -> header bit 5 is 1 only in those multiblocks.
- in_valid dropped on random cycles (~30%) -> headers and FEC are identical to the gap-free run; out_valid mirrors in_valid delayed 1.
- in_mb_start asserted at blk_cnt=17 in RUN -> status_realign pulses once, the next multiblock's fec field is 0, and the following multiblock carries correct fec.
- With JESD204_FEC_HDR_ERR_INJECT_EN, an inject_err pulse -> exactly one multiblock has fec[0] inverted versus the golden model; rst asserted mid-multiblock -> out_valid=0 next cycle and state=IDLE.
